// File: rtl/addsub_seq64_if.sv
// Handshake bus for the sequential adder/subtractor: operand request in,
// result plus flags out, each side on its own valid/ready pair.
interface addsub_seq64_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  // Requester: drives operands and accepts results
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  // Arithmetic block: consumes operands and produces results
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/addsub_seq64.sv
// Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit chunk is added per
// clock through a narrow ripple adder; subtraction is A + ~B + 1.
module addsub_seq64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 8
) (
  input logic           clk,
  input logic           rst,
  addsub_seq64_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SUM_W  = SLICE + 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE:0]   slice_add_c;
  logic [SLICE-1:0] slice_sum_c;
  logic             msb_cin_c;
  logic [WIDTH-1:0] full_sum_c;

  // Narrow ripple adder on the low slice of the operand shift registers
  assign slice_add_c = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + SUM_W'(cy_q);
  assign slice_sum_c = slice_add_c[SLICE-1:0];
  // Carry into the top bit of this slice; only meaningful on the last slice
  assign msb_cin_c   = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum_c[SLICE-1];
  assign full_sum_c  = {slice_sum_c, res_q[WIDTH-1:SLICE]};

  // Next-state, datapath and flag logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.op ? ~bus.b : bus.b;
          cy_d    = bus.op;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d = full_sum_c;
        a_d   = a_q >> SLICE;
        b_d   = b_q >> SLICE;
        cy_d  = slice_add_c[SLICE];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          sum_d   = full_sum_c;
          carry_d = slice_add_c[SLICE];
          ovf_d   = msb_cin_c ^ slice_add_c[SLICE];
          zero_d  = (full_sum_c == '0);
          neg_d   = full_sum_c[WIDTH-1];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;

endmodule

// File: tb/tb_addsub_seq64.sv
// Bench for addsub_seq64: directed operations with literal expectations plus
// a per-cycle comparison against an arithmetic reference model.
module tb_addsub_seq64;

  localparam int unsigned W       = 64;
  localparam int          LATENCY = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edges    = 0;
  int   acc_edge = 0;
  res_t exp_q[$];
  res_t last_res = '0;

  addsub_seq64_if #(.WIDTH(W)) bus ();

  addsub_seq64 #(.WIDTH(W), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic, flags from their definitions
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    res_t              r;
    logic [W:0]        u;
    logic signed [W+1:0] s;
    if (op) begin
      r.sum = a - b;
      r.c   = (a >= b);
      s     = (W+2)'($signed(a)) - (W+2)'($signed(b));
    end else begin
      u     = (W+1)'(a) + (W+1)'(b);
      r.sum = u[W-1:0];
      r.c   = u[W];
      s     = (W+2)'($signed(a)) + (W+2)'($signed(b));
    end
    r.v = (s[W] != s[W-1]);
    r.z = (r.sum == '0);
    r.n = r.sum[W-1];
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.sum, bus.carry, bus.overflow, bus.zero, bus.negative};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model bookkeeping on each rising edge: retire, then accept
  always @(posedge clk) begin
    bit idle_m;
    bit ov_m;
    if (!rst) begin
      idle_m = (exp_q.size() == 0);
      ov_m   = (exp_q.size() > 0) && (edges - acc_edge >= LATENCY);
      if (ov_m && bus.out_ready) last_res = exp_q.pop_front();
      edges++;
      if (idle_m && bus.in_valid) begin
        exp_q.push_back(model(bus.a, bus.b, bus.op));
        acc_edge = edges;
      end
    end else begin
      edges++;
    end
  end

  // Per-cycle comparison of handshake and result outputs against the model
  always @(negedge clk) begin
    res_t e;
    bit   ev;
    bit   er;
    if (rst) begin
      exp_q.delete();
      last_res = '0;
    end
    ev = (exp_q.size() > 0) && (edges - acc_edge >= LATENCY);
    er = (exp_q.size() == 0);
    check("model out_valid", 68'(bus.out_valid), 68'(ev));
    check("model in_ready", 68'(bus.in_ready), 68'(er));
    e = ev ? exp_q[0] : last_res;
    check("model result", 68'(dut_res()), 68'(e));
  end

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic op, input logic [W-1:0] exp_sum,
                        input logic [3:0] exp_flags, input int hold);
    bit got;
    int lat;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.out_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s accept: in_ready never high", name);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s result: out_valid never high", name);
    end
    check({name, " latency"}, 68'(lat), 68'(LATENCY));
    check({name, " sum"}, 68'(bus.sum), 68'(exp_sum));
    check({name, " flags"}, 68'({bus.carry, bus.overflow, bus.zero, bus.negative}), 68'(exp_flags));
    // Backpressure: result held, new requests ignored
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a        = ~a;
      bus.b        = 64'd7;
      check({name, " held sum"}, 68'(bus.sum), 68'(exp_sum));
      check({name, " held in_ready"}, 68'(bus.in_ready), 68'(0));
      check({name, " held out_valid"}, 68'(bus.out_valid), 68'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " retire out_valid"}, 68'(bus.out_valid), 68'(0));
    check({name, " retire in_ready"}, 68'(bus.in_ready), 68'(1));
    check({name, " retire sum kept"}, 68'(bus.sum), 68'(exp_sum));
  endtask

  task automatic reset_mid_calc();
    bit seen;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = 64'h0000_0000_0000_00FF;
    bus.b         = 64'd1;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst mid in_ready", 68'(bus.in_ready), 68'(1));
    check("rst mid out_valid", 68'(bus.out_valid), 68'(0));
    check("rst mid result", 68'(dut_res()), 68'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst discards op", 68'(seen), 68'(0));
    check("rst sum stays 0", 68'(bus.sum), 68'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("reset in_ready", 68'(bus.in_ready), 68'(1));
    check("reset out_valid", 68'(bus.out_valid), 68'(0));
    check("reset result", 68'(dut_res()), 68'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // flags order: {carry, overflow, zero, negative}
    run_op("add 5+3", 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 0);
    run_op("sub 5-3", 64'd5, 64'd3, 1'b1, 64'd2, 4'b1000, 0);
    run_op("sub 3-5", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 0);
    run_op("sub min-1", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b1100, 0);
    run_op("add max+1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b1010, 0);
    run_op("sub 0-0", 64'd0, 64'd0, 1'b1, 64'd0, 4'b1010, 0);
    run_op("sub maxpos-(-1)", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           64'h8000_0000_0000_0000, 4'b0101, 0);
    run_op("add slice carry", 64'h0000_0000_00FF_FFFF, 64'd1, 1'b0,
           64'h0000_0000_0100_0000, 4'b0000, 0);
    run_op("add backpressure", 64'h1234, 64'h1, 1'b0, 64'h1235, 4'b0000, 5);

    reset_mid_calc();

    run_op("add 1+1", 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000, 0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq64.md
# addsub_seq64

Multi-cycle 64-bit adder/subtractor placed directly downstream of the ALU's two's-complement negation stage. Subtraction uses the same negation scheme: operand B is inverted and the carry-in is forced to 1, so A − B = A + ~B + 1. The datapath processes one SLICE-bit chunk per clock through a narrow ripple adder. Operands come in and results go out over valid/ready handshakes, with carry, overflow, zero and negative flags.

## Interface
- WIDTH, 64: operand/result width. Must be an integer multiple of SLICE.
- SLICE, 8: bits added per CALC cycle. Default gives WIDTH/SLICE = 8 cycles.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a, b, op are valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  1  0 = add (A+B), 1 = subtract (A−B).
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.
- negative  out  1  sum[WIDTH-1].

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: processes slices.
  - DONE: out_valid=1.
- IDLE → CALC when in_valid && in_ready on a rising edge. On that edge:
  - latch a into the A shift register;
  - latch (op ? ~b : b) into the B shift register;
  - set the carry register to op;
  - clear the slice counter.
- Each CALC edge:
  - add the low SLICE bits of A, the low SLICE bits of B and the carry register;
  - shift the SLICE-bit sum into the top of the result register; shift A and B right by SLICE;
  - update the carry register; increment the counter.
- On the final slice (counter == WIDTH/SLICE − 1):
  - capture carry into the MSB for overflow;
  - register carry, overflow, zero and negative;
  - go to DONE.
- DONE → IDLE on out_valid && out_ready.
- sum and all flags are held stable from entry into DONE until the next result overwrites them. They stay unchanged in IDLE.
- in_valid while not in IDLE is ignored, and nothing is latched.
- Reset (asynchronous, any state, including mid-CALC):
  - state = IDLE, so in_ready=1 and out_valid=0;
  - sum, carry, overflow, zero, negative = 0;
  - internal registers and counter = 0;
  - an in-flight operation is discarded and produces no output.
- Width rules:
  - sum is truncated to WIDTH bits.
  - Flags describe the truncated result.
  - Subtract of b = 0 gives carry=1.

## Timing
- Accept edge E0 (IDLE→CALC). Slices are processed on edges E1..E(WIDTH/SLICE).
- out_valid rises after edge E(WIDTH/SLICE): 8 cycles after accept by default.
- If out_ready is already high in DONE, the result is taken on the next edge (DONE→IDLE). in_ready rises in the following cycle.
- Minimum spacing between accepts is WIDTH/SLICE + 2 cycles (10 by default).
- in_ready and out_valid are decoded directly from registered state, with no combinational path from in_valid or out_ready.
- Backpressure: DONE persists indefinitely while out_ready=0, with outputs constant.

## Test plan
- Reset, then op=0, a=5, b=3: sum=8, carry=0, overflow=0, zero=0, negative=0. out_valid first high 8 cycles after the accept edge.
- op=1, a=5, b=3: sum=2, carry=1, overflow=0, negative=0.
- op=1, a=3, b=5: sum=0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1, overflow=0.
- op=1, a=0x8000_0000_0000_0000, b=1: sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry=1, negative=0.
- op=0, a=0xFFFF_FFFF_FFFF_FFFF, b=1: sum=0, carry=1, zero=1, overflow=0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE: sum and flags stay constant, in_ready=0, and a second in_valid is ignored.
  - Separately, assert rst during the 4th CALC cycle: out_valid stays 0, sum=0, and in_ready=1 immediately.
  - A fresh op=0, a=1, b=1 then completes with sum=2.
